// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I decode constants: instr_bus bit map, ALU codes, opcodes, immediate formats
package rv_pkg;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_XOR   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_AND   = 4;
  localparam int OP_SLL   = 5;
  localparam int OP_SRL   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_SLTU  = 9;
  localparam int OP_ADDI  = 10;
  localparam int OP_XORI  = 11;
  localparam int OP_ORI   = 12;
  localparam int OP_ANDI  = 13;
  localparam int OP_SLLI  = 14;
  localparam int OP_SRLI  = 15;
  localparam int OP_SRAI  = 16;
  localparam int OP_SLTI  = 17;
  localparam int OP_SLTIU = 18;
  localparam int OP_LB    = 19;
  localparam int OP_LH    = 20;
  localparam int OP_LW    = 21;
  localparam int OP_LBU   = 22;
  localparam int OP_LHU   = 23;
  localparam int OP_SB    = 24;
  localparam int OP_SH    = 25;
  localparam int OP_SW    = 26;
  localparam int OP_BEQ   = 27;
  localparam int OP_BNE   = 28;
  localparam int OP_BLT   = 29;
  localparam int OP_BGE   = 30;
  localparam int OP_BLTU  = 31;
  localparam int OP_BGEU  = 32;
  localparam int OP_JAL   = 33;
  localparam int OP_JALR  = 34;
  localparam int OP_LUI   = 35;
  localparam int OP_AUIPC = 36;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_XOR   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SHAMT
  } imm_fmt_e;

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational immediate extraction for the RV32I instruction formats
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:7] instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic sgn;
  assign sgn = instr[XLEN-1];

  always_comb begin
    imm = '0;
    unique case (fmt)
      FMT_I:     imm = {{(XLEN-12){sgn}}, instr[31:20]};
      FMT_S:     imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
      FMT_B:     imm = {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:     imm = {instr[31:12], 12'b0};
      FMT_J:     imm = {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_SHAMT: imm = {{(XLEN-5){1'b0}}, instr[24:20]};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I decode slot with valid/ready handshake and flush
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_OPS = 37
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OPS-1:0] instr_bus,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         rd_addr,
  output logic [XLEN-1:0]    extend,
  output logic               imm_valid,
  output logic [3:0]         ctrl,
  output logic               illegal,
  output logic [XLEN-1:0]    out_pc
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  logic [NUM_OPS-1:0] op_c;
  imm_fmt_e           fmt_c;
  logic               immv_c;
  logic [3:0]         ctrl_c;
  logic               ill_c;
  logic [XLEN-1:0]    imm_c;

  always_comb begin
    op_c   = '0;
    fmt_c  = FMT_NONE;
    immv_c = 1'b0;
    ctrl_c = ALU_ADD;
    ill_c  = 1'b0;
    unique case (opc)
      OPC_OP: begin
        if (f7 == 7'h00) begin
          unique case (f3)
            3'd0: begin op_c[OP_ADD]  = 1'b1; ctrl_c = ALU_ADD;  end
            3'd1: begin op_c[OP_SLL]  = 1'b1; ctrl_c = ALU_SLL;  end
            3'd2: begin op_c[OP_SLT]  = 1'b1; ctrl_c = ALU_SLT;  end
            3'd3: begin op_c[OP_SLTU] = 1'b1; ctrl_c = ALU_SLTU; end
            3'd4: begin op_c[OP_XOR]  = 1'b1; ctrl_c = ALU_XOR;  end
            3'd5: begin op_c[OP_SRL]  = 1'b1; ctrl_c = ALU_SRL;  end
            3'd6: begin op_c[OP_OR]   = 1'b1; ctrl_c = ALU_OR;   end
            default: begin op_c[OP_AND] = 1'b1; ctrl_c = ALU_AND; end
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          op_c[OP_SUB] = 1'b1; ctrl_c = ALU_SUB;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          op_c[OP_SRA] = 1'b1; ctrl_c = ALU_SRA;
        end else begin
          ill_c = 1'b1;
        end
      end
      OPC_OPIMM: begin
        immv_c = 1'b1;
        fmt_c  = FMT_I;
        unique case (f3)
          3'd0: begin op_c[OP_ADDI]  = 1'b1; ctrl_c = ALU_ADD;  end
          3'd2: begin op_c[OP_SLTI]  = 1'b1; ctrl_c = ALU_SLT;  end
          3'd3: begin op_c[OP_SLTIU] = 1'b1; ctrl_c = ALU_SLTU; end
          3'd4: begin op_c[OP_XORI]  = 1'b1; ctrl_c = ALU_XOR;  end
          3'd6: begin op_c[OP_ORI]   = 1'b1; ctrl_c = ALU_OR;   end
          3'd7: begin op_c[OP_ANDI]  = 1'b1; ctrl_c = ALU_AND;  end
          3'd1: begin
            fmt_c = FMT_SHAMT;
            if (f7 == 7'h00) begin op_c[OP_SLLI] = 1'b1; ctrl_c = ALU_SLL; end
            else ill_c = 1'b1;
          end
          default: begin
            fmt_c = FMT_SHAMT;
            if (f7 == 7'h00)      begin op_c[OP_SRLI] = 1'b1; ctrl_c = ALU_SRL; end
            else if (f7 == 7'h20) begin op_c[OP_SRAI] = 1'b1; ctrl_c = ALU_SRA; end
            else ill_c = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        immv_c = 1'b1;
        fmt_c  = FMT_I;
        unique case (f3)
          3'd0: op_c[OP_LB]  = 1'b1;
          3'd1: op_c[OP_LH]  = 1'b1;
          3'd2: op_c[OP_LW]  = 1'b1;
          3'd4: op_c[OP_LBU] = 1'b1;
          3'd5: op_c[OP_LHU] = 1'b1;
          default: ill_c = 1'b1;
        endcase
      end
      OPC_STORE: begin
        immv_c = 1'b1;
        fmt_c  = FMT_S;
        unique case (f3)
          3'd0: op_c[OP_SB] = 1'b1;
          3'd1: op_c[OP_SH] = 1'b1;
          3'd2: op_c[OP_SW] = 1'b1;
          default: ill_c = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        fmt_c = FMT_B;
        unique case (f3)
          3'd0: begin op_c[OP_BEQ]  = 1'b1; ctrl_c = ALU_SUB;  end
          3'd1: begin op_c[OP_BNE]  = 1'b1; ctrl_c = ALU_SUB;  end
          3'd4: begin op_c[OP_BLT]  = 1'b1; ctrl_c = ALU_SLT;  end
          3'd5: begin op_c[OP_BGE]  = 1'b1; ctrl_c = ALU_SLT;  end
          3'd6: begin op_c[OP_BLTU] = 1'b1; ctrl_c = ALU_SLTU; end
          3'd7: begin op_c[OP_BGEU] = 1'b1; ctrl_c = ALU_SLTU; end
          default: ill_c = 1'b1;
        endcase
      end
      OPC_JAL: begin
        fmt_c = FMT_J;
        op_c[OP_JAL] = 1'b1;
      end
      OPC_JALR: begin
        fmt_c  = FMT_I;
        immv_c = 1'b1;
        if (f3 == 3'd0) op_c[OP_JALR] = 1'b1;
        else ill_c = 1'b1;
      end
      OPC_LUI: begin
        fmt_c  = FMT_U;
        immv_c = 1'b1;
        ctrl_c = ALU_PASSB;
        op_c[OP_LUI] = 1'b1;
      end
      OPC_AUIPC: begin
        fmt_c  = FMT_U;
        immv_c = 1'b1;
        op_c[OP_AUIPC] = 1'b1;
      end
      default: ill_c = 1'b1;
    endcase
    // An illegal word still travels down the pipe, but with a quiet payload.
    if (ill_c) begin
      op_c   = '0;
      fmt_c  = FMT_NONE;
      immv_c = 1'b0;
      ctrl_c = ALU_ADD;
    end
  end

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[XLEN-1:7]),
    .fmt   (fmt_c),
    .imm   (imm_c)
  );

  logic               valid_q, valid_d;
  logic [NUM_OPS-1:0] bus_q, bus_d;
  logic [4:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]    ext_q, ext_d, pc_q, pc_d;
  logic               immv_q, immv_d, ill_q, ill_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ext_d   = ext_q;
    pc_d    = pc_q;
    immv_d  = immv_q;
    ill_d   = ill_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      bus_d   = op_c;
      rs1_d   = in_instr[19:15];
      rs2_d   = in_instr[24:20];
      rd_d    = in_instr[11:7];
      ext_d   = imm_c;
      pc_d    = in_pc;
      immv_d  = immv_c;
      ill_d   = ill_c;
      ctrl_d  = ctrl_c;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ext_q   <= '0;
      pc_q    <= '0;
      immv_q  <= 1'b0;
      ill_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ext_q   <= ext_d;
      pc_q    <= pc_d;
      immv_q  <= immv_d;
      ill_q   <= ill_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign instr_bus = bus_q;
  assign rs1_addr  = rs1_q;
  assign rs2_addr  = rs2_q;
  assign rd_addr   = rd_q;
  assign extend    = ext_q;
  assign imm_valid = immv_q;
  assign ctrl      = ctrl_q;
  assign illegal   = ill_q;
  assign out_pc    = pc_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - directed self-checking bench for rv_decode_stage
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, extend, out_pc;
  logic [36:0] instr_bus;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        imm_valid, illegal;
  logic [3:0]  ctrl;

  int errors = 0;
  int checks = 0;

  rv_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .instr_bus(instr_bus),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .extend(extend), .imm_valid(imm_valid), .ctrl(ctrl),
    .illegal(illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1);
  end

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic rdy);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (instr_bus !== 37'h0) begin errors++; $display("FAIL reset_bus got %h want 0", instr_bus); end
    checks++; if (extend !== 32'h0) begin errors++; $display("FAIL reset_extend got %h want 0", extend); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b want 0", illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_add();
    issue(32'h002081B3, 32'h10, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", out_valid); end
    checks++; if (instr_bus !== 37'h1) begin errors++; $display("FAIL add_bus got %h want %h", instr_bus, 37'h1); end
    checks++; if (rs1_addr !== 5'd1) begin errors++; $display("FAIL add_rs1 got %0d want 1", rs1_addr); end
    checks++; if (rs2_addr !== 5'd2) begin errors++; $display("FAIL add_rs2 got %0d want 2", rs2_addr); end
    checks++; if (rd_addr !== 5'd3) begin errors++; $display("FAIL add_rd got %0d want 3", rd_addr); end
    checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL add_immv got %0b want 0", imm_valid); end
    checks++; if (ctrl !== 4'd0) begin errors++; $display("FAIL add_ctrl got %0d want 0", ctrl); end
    checks++; if (extend !== 32'h0) begin errors++; $display("FAIL add_extend got %h want 0", extend); end
    checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL add_pc got %h want 10", out_pc); end
  endtask

  task automatic test_imm_formats();
    issue(32'hFFF00093, 32'h14, 1'b1);
    checks++; if (instr_bus !== (37'h1 << 10)) begin errors++; $display("FAIL addi_bus got %h want bit10", instr_bus); end
    checks++; if (extend !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_extend got %h want ffffffff", extend); end
    checks++; if (imm_valid !== 1'b1) begin errors++; $display("FAIL addi_immv got %0b want 1", imm_valid); end
    checks++; if (rd_addr !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", rd_addr); end
    issue(32'h0020A423, 32'h18, 1'b1);
    checks++; if (instr_bus !== (37'h1 << 26)) begin errors++; $display("FAIL sw_bus got %h want bit26", instr_bus); end
    checks++; if (extend !== 32'h8) begin errors++; $display("FAIL sw_extend got %h want 8", extend); end
    checks++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin errors++; $display("FAIL sw_regs got %0d,%0d want 1,2", rs1_addr, rs2_addr); end
    issue(32'hFE000EE3, 32'h1C, 1'b1);
    checks++; if (instr_bus !== (37'h1 << 27)) begin errors++; $display("FAIL beq_bus got %h want bit27", instr_bus); end
    checks++; if (extend !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_extend got %h want fffffffc", extend); end
    checks++; if (ctrl !== 4'd1) begin errors++; $display("FAIL beq_ctrl got %0d want 1", ctrl); end
    checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL beq_immv got %0b want 0", imm_valid); end
    checks++; if (rd_addr !== 5'd29) begin errors++; $display("FAIL beq_rd got %0d want 29", rd_addr); end
    issue(32'h40335293, 32'h20, 1'b1);
    checks++; if (instr_bus !== (37'h1 << 16)) begin errors++; $display("FAIL srai_bus got %h want bit16", instr_bus); end
    checks++; if (extend !== 32'h3) begin errors++; $display("FAIL srai_extend got %h want 3", extend); end
    checks++; if (ctrl !== 4'd7) begin errors++; $display("FAIL srai_ctrl got %0d want 7", ctrl); end
    issue(32'h123453B7, 32'h24, 1'b1);
    checks++; if (instr_bus !== (37'h1 << 35)) begin errors++; $display("FAIL lui_bus got %h want bit35", instr_bus); end
    checks++; if (extend !== 32'h12345000) begin errors++; $display("FAIL lui_extend got %h want 12345000", extend); end
    checks++; if (ctrl !== 4'd10) begin errors++; $display("FAIL lui_ctrl got %0d want 10", ctrl); end
    issue(32'h008000EF, 32'h28, 1'b1);
    checks++; if (instr_bus !== (37'h1 << 33)) begin errors++; $display("FAIL jal_bus got %h want bit33", instr_bus); end
    checks++; if (extend !== 32'h8) begin errors++; $display("FAIL jal_extend got %h want 8", extend); end
    checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL jal_immv got %0b want 0", imm_valid); end
  endtask

  task automatic test_illegal();
    issue(32'h00000000, 32'h30, 1'b1);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill0_flag got %0b want 1", illegal); end
    checks++; if (instr_bus !== 37'h0) begin errors++; $display("FAIL ill0_bus got %h want 0", instr_bus); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill0_valid got %0b want 1", out_valid); end
    issue(32'h40007033, 32'h34, 1'b1);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill20_flag got %0b want 1", illegal); end
    checks++; if (instr_bus !== 37'h0) begin errors++; $display("FAIL ill20_bus got %h want 0", instr_bus); end
    checks++; if (ctrl !== 4'd0) begin errors++; $display("FAIL ill20_ctrl got %0d want 0", ctrl); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill20_valid got %0b want 1", out_valid); end
    issue(32'h002081B3, 32'h38, 1'b1);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear got %0b want 0", illegal); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s_instr [4];
    logic [31:0] s_pc    [4];
    int          s_bit   [4];
    int          sent, rcv;
    logic        held_chk, did_acc, did_drain;
    logic [31:0] held_pc;
    logic [36:0] held_bus;
    s_instr[0] = 32'h002081B3; s_bit[0] = 0;  s_pc[0] = 32'h100;
    s_instr[1] = 32'hFFF00093; s_bit[1] = 10; s_pc[1] = 32'h104;
    s_instr[2] = 32'h0020A423; s_bit[2] = 26; s_pc[2] = 32'h108;
    s_instr[3] = 32'hFE000EE3; s_bit[3] = 27; s_pc[3] = 32'h10C;
    sent = 0; rcv = 0; held_chk = 1'b0; held_pc = '0; held_bus = '0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 4);
      in_instr  = (sent < 4) ? s_instr[sent] : 32'h0;
      in_pc     = (sent < 4) ? s_pc[sent] : 32'h0;
      #1;
      if (held_chk) begin
        checks++;
        if (out_pc !== held_pc || instr_bus !== held_bus) begin
          errors++; $display("FAIL stall_stable got pc=%h bus=%h want pc=%h bus=%h", out_pc, instr_bus, held_pc, held_bus);
        end
      end
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
      end
      if (out_valid && rcv >= 4) begin
        checks++; errors++; $display("FAIL stream_dup got out_valid=1 pc=%h want no extra bundle", out_pc);
      end
      did_acc   = in_valid && in_ready;
      did_drain = out_valid && out_ready;
      if (did_drain && rcv < 4) begin
        checks++;
        if (out_pc !== s_pc[rcv] || instr_bus !== (37'h1 << s_bit[rcv])) begin
          errors++; $display("FAIL stream_order got pc=%h bus=%h want pc=%h bit%0d", out_pc, instr_bus, s_pc[rcv], s_bit[rcv]);
        end
        rcv++;
      end
      held_chk = out_valid && !out_ready;
      held_pc  = out_pc;
      held_bus = instr_bus;
      @(posedge clk); #1;
      if (did_acc) sent++;
    end
    in_valid = 1'b0;
    checks++; if (rcv !== 4) begin errors++; $display("FAIL stream_count got %0d want 4", rcv); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    issue(32'h002081B3, 32'h200, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_fill got %0b want 1", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h204; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full got %0b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %0b want 0", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h208; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %0b pc=%h want 0", out_valid, out_pc); end
    issue(32'hFFFFFFFF, 32'h300, 1'b0);
    checks++; if (illegal !== 1'b1 || rd_addr !== 5'd31) begin errors++; $display("FAIL rst_fill got ill=%0b rd=%0d want 1,31", illegal, rd_addr); end
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h304;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %0b want 0", illegal); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", out_pc); end
    checks++; if (rd_addr !== 5'd0 || rs1_addr !== 5'd0 || rs2_addr !== 5'd0) begin errors++; $display("FAIL rst_regs got %0d,%0d,%0d want 0,0,0", rs1_addr, rs2_addr, rd_addr); end
    checks++; if (instr_bus !== 37'h0 || ctrl !== 4'd0 || imm_valid !== 1'b0 || extend !== 32'h0) begin errors++; $display("FAIL rst_fields got bus=%h ctrl=%0d immv=%0b ext=%h want 0", instr_bus, ctrl, imm_valid, extend); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm_formats();
    test_illegal();
    test_back_to_back();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
